// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer
//  Description : Staged reset release sequencer. After the upstream RESET is
//                released (deassertion re-timed through a 2-flop
//                synchroniser), the core, peripheral and comms resets are
//                released one stage at a time. In RUN, a software request or
//                (optionally) a watchdog expiry restarts the sequence.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    HOLD_CYCLES    cycles all resets stay asserted after synchronised release
//    STAGE_DELAY    cycles between successive stage releases
//    WDT_TIMEOUT    watchdog timeout in cycles
//  Ports
//    CLK_48MHZ      in   1  sole clock, rising edge
//    RESET          in   1  asynchronous active-high reset
//    SOFT_RESET_REQ in   1  software reset request (rising edge acts in RUN)
//    WDT_KICK       in   1  watchdog service strobe
//    RST_CORE       out  1  stage-1 reset, active high
//    RST_PERIPH     out  1  stage-2 reset, active high
//    RST_COMMS      out  1  stage-3 reset, active high
//    RESET_DONE     out  1  all stages released
//    RESET_COUNT    out  8  soft/watchdog resets since last RESET (saturating)
//    WDT_FIRED      out  1  sticky watchdog-expiry flag
//  Configuration
//    RESET_SEQ_WDT_EN  when defined, builds the watchdog; otherwise WDT_KICK
//                      is ignored and WDT_FIRED is tied low.
// ============================================================================
module reset_sequencer #(
    parameter int HOLD_CYCLES = 48,
    parameter int STAGE_DELAY = 480,
    parameter int WDT_TIMEOUT = 4800000
) (
    input  logic       CLK_48MHZ,
    input  logic       RESET,
    input  logic       SOFT_RESET_REQ,
    input  logic       WDT_KICK,
    output logic       RST_CORE,
    output logic       RST_PERIPH,
    output logic       RST_COMMS,
    output logic       RESET_DONE,
    output logic [7:0] RESET_COUNT,
    output logic       WDT_FIRED
);

    // The shared delay counter only ever needs to reach max(HOLD, STAGE)-1.
    localparam int MAX_DELAY = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
    localparam int CNT_W     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);

    typedef enum logic [1:0] {
        S_HOLD       = 2'd0,
        S_REL_CORE   = 2'd1,
        S_REL_PERIPH = 2'd2,
        S_RUN        = 2'd3
    } state_t;

    logic [1:0]       sync_q, sync_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_core_q, rst_core_d;
    logic             rst_periph_q, rst_periph_d;
    logic             rst_comms_q, rst_comms_d;
    logic             done_q, done_d;
    logic [7:0]       count_q, count_d;
    logic             soft_prev_q, soft_prev_d;

    logic             released;
    logic             soft_trig;
    logic             wdt_fire;
    logic             reseq;

    // Assertion of RESET clears sync_q asynchronously; release only becomes
    // visible to the sequencer after two clean clock edges.
    assign released = sync_q[1];

    // Edge detect: a level already high when RUN is (re)entered never fires.
    assign soft_trig = (state_q == S_RUN) && SOFT_RESET_REQ && !soft_prev_q;
    assign reseq     = soft_trig || wdt_fire;

    always_comb begin
        sync_d       = {sync_q[0], 1'b1};
        soft_prev_d  = SOFT_RESET_REQ;
        state_d      = state_q;
        cnt_d        = cnt_q;
        rst_core_d   = rst_core_q;
        rst_periph_d = rst_periph_q;
        rst_comms_d  = rst_comms_q;
        done_d       = done_q;
        count_d      = count_q;

        if (released) begin
            if (reseq) begin
                // Soft and watchdog causes coinciding count as one event.
                state_d      = S_HOLD;
                cnt_d        = '0;
                rst_core_d   = 1'b1;
                rst_periph_d = 1'b1;
                rst_comms_d  = 1'b1;
                done_d       = 1'b0;
                if (count_q != 8'hFF) begin
                    count_d = count_q + 8'd1;
                end
            end else begin
                case (state_q)
                    S_HOLD: begin
                        if (cnt_q == HOLD_LAST) begin
                            rst_core_d = 1'b0;
                            state_d    = S_REL_CORE;
                            cnt_d      = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    S_REL_CORE: begin
                        if (cnt_q == STAGE_LAST) begin
                            rst_periph_d = 1'b0;
                            state_d      = S_REL_PERIPH;
                            cnt_d        = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    S_REL_PERIPH: begin
                        if (cnt_q == STAGE_LAST) begin
                            rst_comms_d = 1'b0;
                            done_d      = 1'b1;
                            state_d     = S_RUN;
                            cnt_d       = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = S_RUN;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK_48MHZ or posedge RESET) begin
        if (RESET) begin
            sync_q       <= 2'b00;
            soft_prev_q  <= 1'b0;
            state_q      <= S_HOLD;
            cnt_q        <= '0;
            rst_core_q   <= 1'b1;
            rst_periph_q <= 1'b1;
            rst_comms_q  <= 1'b1;
            done_q       <= 1'b0;
            count_q      <= 8'd0;
        end else begin
            sync_q       <= sync_d;
            soft_prev_q  <= soft_prev_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rst_core_q   <= rst_core_d;
            rst_periph_q <= rst_periph_d;
            rst_comms_q  <= rst_comms_d;
            done_q       <= done_d;
            count_q      <= count_d;
        end
    end

`ifdef RESET_SEQ_WDT_EN
    localparam int WDT_W = (WDT_TIMEOUT > 1) ? $clog2(WDT_TIMEOUT) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_TIMEOUT - 1);

    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
    logic             wdt_fired_q, wdt_fired_d;

    // A kick on the expiry cycle suppresses the expiry.
    assign wdt_fire = (state_q == S_RUN) && !WDT_KICK && (wdt_cnt_q == WDT_LAST);

    always_comb begin
        wdt_fired_d = wdt_fired_q | wdt_fire;
        if ((state_q != S_RUN) || WDT_KICK || reseq) begin
            wdt_cnt_d = '0;
        end else begin
            wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
        end
    end

    always_ff @(posedge CLK_48MHZ or posedge RESET) begin
        if (RESET) begin
            wdt_cnt_q   <= '0;
            wdt_fired_q <= 1'b0;
        end else begin
            wdt_cnt_q   <= wdt_cnt_d;
            wdt_fired_q <= wdt_fired_d;
        end
    end

    assign WDT_FIRED = wdt_fired_q;
`else
    logic [31:0] unused_wdt_cfg;
    logic        unused_wdt_kick;

    assign unused_wdt_cfg  = 32'(WDT_TIMEOUT);
    assign unused_wdt_kick = WDT_KICK;
    assign wdt_fire        = 1'b0;
    assign WDT_FIRED       = 1'b0;
`endif

    assign RST_CORE    = rst_core_q;
    assign RST_PERIPH  = rst_periph_q;
    assign RST_COMMS   = rst_comms_q;
    assign RESET_DONE  = done_q;
    assign RESET_COUNT = count_q;

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 48; cycles all resets stay asserted after the synchronised release.
REQ-002 Parameter STAGE_DELAY, default 480; cycles between successive stage releases.
REQ-003 Parameter WDT_TIMEOUT, default 4800000; watchdog timeout in cycles.
REQ-004 CLK_48MHZ  input  1  sole clock, all logic on rising edge.
REQ-005 RESET  input  1  asynchronous active-high reset, driven by the upstream reset-pulse stage.
REQ-006 SOFT_RESET_REQ  input  1  synchronous software reset request.
REQ-007 WDT_KICK  input  1  synchronous watchdog service strobe.
REQ-008 RST_CORE  output  1  active-high reset, stage 1.
REQ-009 RST_PERIPH  output  1  active-high reset, stage 2.
REQ-010 RST_COMMS  output  1  active-high reset, stage 3.
REQ-011 RESET_DONE  output  1  high when all stages are released.
REQ-012 RESET_COUNT  output  8  count of soft/watchdog resets since the last RESET.
REQ-013 WDT_FIRED  output  1  sticky watchdog-expiry flag.

Function
REQ-014 States SHALL be HOLD, REL_CORE, REL_PERIPH, RUN, each with a single shared delay counter.
REQ-015 RESET deassertion SHALL pass a 2-flop synchroniser; assertion SHALL take effect asynchronously.
REQ-016 HOLD SHALL count HOLD_CYCLES, then deassert RST_CORE and enter REL_CORE.
REQ-017 REL_CORE SHALL count STAGE_DELAY, then deassert RST_PERIPH and enter REL_PERIPH.
REQ-018 REL_PERIPH SHALL count STAGE_DELAY, then deassert RST_COMMS, assert RESET_DONE and enter RUN.
REQ-019 Relative to the first rising edge with RESET low: RST_CORE falls at edge HOLD_CYCLES+2, RST_PERIPH at HOLD_CYCLES+2+STAGE_DELAY, RST_COMMS and RESET_DONE at HOLD_CYCLES+2+2*STAGE_DELAY.
REQ-020 Outputs SHALL be registered, glitch-free and monotonic within a sequence.
REQ-021 In RUN, a 0->1 edge on SOFT_RESET_REQ SHALL assert all RST_* and clear RESET_DONE on the next edge, and re-enter HOLD with the counter cleared.
REQ-022 A held-high SOFT_RESET_REQ SHALL trigger once; it SHALL be ignored outside RUN, but an edge arriving in RUN after a level held high SHALL not trigger.
REQ-023 Each soft or watchdog reset SHALL increment RESET_COUNT by 1, saturating at 255.
REQ-024 A simultaneous soft request and watchdog expiry SHALL count as one event (+1).
REQ-025 Soft and watchdog resets SHALL NOT clear RESET_COUNT or WDT_FIRED.

Reset
REQ-026 While RESET is high: RST_CORE=RST_PERIPH=RST_COMMS=1, RESET_DONE=0, RESET_COUNT=0, WDT_FIRED=0, state HOLD, all counters 0.
REQ-027 RESET asserted in any state, including mid-sequence, SHALL force the REQ-026 values immediately, without waiting for a clock.

Configuration
REQ-028 With macro RESET_SEQ_WDT_EN defined, a watchdog counter SHALL run only in RUN and clear on WDT_KICK or on leaving RUN.
REQ-029 With RESET_SEQ_WDT_EN defined, the counter reaching WDT_TIMEOUT-1 without a kick SHALL set WDT_FIRED and trigger a soft reset per REQ-021.
REQ-030 A kick on the expiry cycle SHALL win and prevent the reset.
REQ-031 Without RESET_SEQ_WDT_EN: no counter is built, WDT_KICK is ignored, WDT_FIRED is tied 0, and watchdog resets never occur.

Verification
REQ-032 HOLD_CYCLES=4, STAGE_DELAY=8, RESET pulsed then released -> RST_CORE falls at edge 6, RST_PERIPH at edge 14, RST_COMMS/RESET_DONE at edge 22.
REQ-033 RESET reasserted at edge 10 of a sequence -> all RST_* high before the next edge; the sequence restarts on release.
REQ-034 In RUN, SOFT_RESET_REQ held high 20 cycles -> exactly one resequence; RESET_COUNT=1.
REQ-035 In RUN, 300 soft-request pulses -> RESET_COUNT=255, no wrap.
REQ-036 With RESET_SEQ_WDT_EN, WDT_TIMEOUT=100, no kicks -> resequence at RUN cycle 100, WDT_FIRED=1, RESET_COUNT=1; a kick every 50 cycles -> no reset.
REQ-037 Without RESET_SEQ_WDT_EN, 10^6 RUN cycles with no kick -> RESET_DONE stays 1, WDT_FIRED=0.
